// File: rtl/branch_pkg.sv
// branch_pkg: shared branch condition codes, compare encodings and sequencer states
package branch_pkg;
  localparam logic [2:0] BR_LT = 3'd2;
  localparam logic [2:0] BR_GE = 3'd3;
  localparam logic [2:0] BR_EQ = 3'd4;
  localparam logic [2:0] BR_NE = 3'd5;
  localparam logic [2:0] BR_LE = 3'd6;
  localparam logic [2:0] BR_GT = 3'd7;
  localparam logic [1:0] CMP_LT = 2'b10;
  localparam logic [1:0] CMP_EQ = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b00;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIRECT} state_e;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition truth table (want x compare result)
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] want_i,
  input  logic [1:0] cond_i,
  output logic       taken_o,
  output logic       illegal_o
);
  logic lt, eq, gt;
  // An illegal compare result never takes a branch, whatever the condition code
  always_comb begin
    lt = cond_i == CMP_LT;
    eq = cond_i == CMP_EQ;
    gt = cond_i == CMP_GT;
    illegal_o = cond_i == 2'b11;
    taken_o = !illegal_o && (want_i == BR_LT ? lt :
                             want_i == BR_GE ? gt || eq :
                             want_i == BR_EQ ? eq :
                             want_i == BR_NE ? !eq :
                             want_i == BR_LE ? lt || eq :
                             want_i == BR_GT ? gt : 1'b0);
  end
endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: holds fetch while a branch compare is in flight, then redirects on taken; BRANCH_STATS_EN adds taken/resolved counters
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  input  logic [2:0]      br_want,
  input  logic [PC_W-1:0] br_target,
  output logic            br_ready,
  input  logic            cmp_valid,
  input  logic [1:0]      cmp_cond,
  input  logic            kill,
  output logic            stall,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            err,
  output logic [31:0]     taken_cnt,
  output logic [31:0]     resolved_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic [2:0] want_q, want_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic accept, in_wait, idle_wait, resolve, expire, taken, illegal;
  branch_cond_eval u_eval (
    .want_i   (want_q),
    .cond_i   (cmp_cond),
    .taken_o  (taken),
    .illegal_o(illegal)
  );
  assign accept    = state_q == S_IDLE && br_valid && br_want >= BR_LT;
  assign in_wait   = state_q == S_WAIT;
  assign resolve   = in_wait && !kill && cmp_valid;
  assign idle_wait = in_wait && !kill && !cmp_valid;
  assign expire    = idle_wait && cnt_q == TW'(TIMEOUT_CYCLES - 1);
  // State and latched branch context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      want_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      want_q   <= want_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
  // Next state: kill beats a compare result, which beats the timeout
  always_comb begin
    state_d  = accept ? S_WAIT :
               state_q == S_REDIRECT ? S_IDLE :
               in_wait && (kill || cmp_valid || expire) ? (resolve && taken ? S_REDIRECT : S_IDLE) :
               state_q;
    want_d   = accept ? br_want : want_q;
    target_d = accept ? br_target : target_q;
    cnt_d    = accept ? '0 : idle_wait ? cnt_q + 1'b1 : cnt_q;
    err_d    = (resolve && illegal) || expire;
  end
  // Outputs decoded from state; kill only masks the redirect pulse itself
  always_comb begin
    br_ready    = state_q == S_IDLE;
    stall       = in_wait;
    redirect    = state_q == S_REDIRECT && !kill;
    flush       = redirect;
    redirect_pc = state_q == S_REDIRECT ? target_q : '0;
    err         = err_q;
  end
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_q, resolved_q;
  // Counters advance at the resolving edge, so a later kill of the redirect still counts as taken
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q    <= '0;
      resolved_q <= '0;
    end else begin
      if (resolve && !illegal) resolved_q <= resolved_q + 32'd1;
      if (resolve && taken) taken_q <= taken_q + 32'd1;
    end
  end
  assign taken_cnt    = taken_q;
  assign resolved_cnt = resolved_q;
`else
  assign taken_cnt    = '0;
  assign resolved_cnt = '0;
`endif
endmodule
